// File: rtl/rvc_pkg.sv
// Shared definitions for the RVC compress/pack datapath: RV32I opcodes,
// RVC quadrant codes, the compressed no-op and the packer state type.
package rvc_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [1:0] Q0 = 2'b00;
   localparam logic [1:0] Q1 = 2'b01;
   localparam logic [1:0] Q2 = 2'b10;

   localparam logic [15:0] C_NOP       = 16'h0001;
   localparam logic [31:0] EBREAK_INST = 32'h00100073;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } pk_state_t;

   // True for the eight registers reachable through a 3-bit RVC field (x8-x15).
   function automatic logic is_creg(input logic [4:0] r);
      return r[4:3] == 2'b01;
   endfunction

endpackage

// File: rtl/rvc_encoder.sv
// Combinational RV32I -> RVC encoder. Produces is_c=1 and the 16-bit form
// only for the supported subset; anything else reports is_c=0.
module rvc_encoder
   import rvc_pkg::*;
(
   input  logic [31:0] in_inst,
   output logic        is_c,
   output logic [15:0] c16
);

   logic [6:0] opc;
   logic [4:0] rd;
   logic [2:0] f3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] f7;
   logic       imm_small;
   logic       lui_small;

   assign opc = in_inst[6:0];
   assign rd  = in_inst[11:7];
   assign f3  = in_inst[14:12];
   assign rs1 = in_inst[19:15];
   assign rs2 = in_inst[24:20];
   assign f7  = in_inst[31:25];

   // I-immediate fits a 6-bit signed field when its upper seven bits are a sign run.
   assign imm_small = (f7 == 7'h00) || (f7 == 7'h7F);
   // U-immediate fits a 6-bit signed field when bits 31..17 are a sign run.
   assign lui_small = (in_inst[31:17] == '0) || (in_inst[31:17] == '1);

   // Recognise each compressible form and assemble its 16-bit encoding.
   always_comb begin
      is_c = 1'b0;
      c16  = '0;
      case (opc)
         LOAD: begin
            if (f3 == 3'b010 && is_creg(rd) && is_creg(rs1) &&
                in_inst[31:27] == '0 && in_inst[21:20] == '0) begin
               is_c = 1'b1;
               c16  = {3'b010, in_inst[25:23], rs1[2:0], in_inst[22], in_inst[26], rd[2:0], Q0};
            end
         end
         STORE: begin
            if (f3 == 3'b010 && is_creg(rs1) && is_creg(rs2) &&
                in_inst[31:27] == '0 && in_inst[8:7] == '0) begin
               is_c = 1'b1;
               c16  = {3'b110, in_inst[25], in_inst[11:10], rs1[2:0], in_inst[9], in_inst[26],
                       rs2[2:0], Q0};
            end
         end
         OP_IMM: begin
            case (f3)
               3'b000: begin
                  if (rd == rs1 && rd != '0 && imm_small && in_inst[31:20] != '0) begin
                     is_c = 1'b1;
                     c16  = {3'b000, in_inst[25], rd, in_inst[24:20], Q1};
                  end
               end
               3'b001: begin
                  if (f7 == '0 && rd == rs1 && rd != '0 && rs2 != '0) begin
                     is_c = 1'b1;
                     c16  = {3'b000, 1'b0, rd, rs2, Q2};
                  end
               end
               3'b101: begin
                  if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd == rs1 && is_creg(rd) &&
                      rs2 != '0) begin
                     is_c = 1'b1;
                     c16  = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, Q1};
                  end
               end
               3'b111: begin
                  if (f7 == '0 && rd == rs1 && is_creg(rd) && in_inst[24:20] != '0) begin
                     is_c = 1'b1;
                     c16  = {3'b100, 1'b0, 2'b10, rd[2:0], in_inst[24:20], Q1};
                  end
               end
               default: ;
            endcase
         end
         LUI: begin
            if (rd != 5'd0 && rd != 5'd2 && lui_small && in_inst[31:12] != '0) begin
               is_c = 1'b1;
               c16  = {3'b011, in_inst[17], rd, in_inst[16:12], Q1};
            end
         end
         OP: begin
            if (rd == rs1) begin
               if (f7 == 7'b0100000 && f3 == 3'b000 && is_creg(rd) && is_creg(rs2)) begin
                  is_c = 1'b1;
                  c16  = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], Q1};
               end else if (f7 == '0 && f3 == 3'b100 && is_creg(rd) && is_creg(rs2)) begin
                  is_c = 1'b1;
                  c16  = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], Q1};
               end else if (f7 == '0 && f3 == 3'b110 && is_creg(rd) && is_creg(rs2)) begin
                  is_c = 1'b1;
                  c16  = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], Q1};
               end else if (f7 == '0 && f3 == 3'b111 && is_creg(rd) && is_creg(rs2)) begin
                  is_c = 1'b1;
                  c16  = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], Q1};
               end else if (f7 == '0 && f3 == 3'b000 && rd != '0 && rs2 != '0) begin
                  is_c = 1'b1;
                  c16  = {3'b100, 1'b1, rd, rs2, Q2};
               end
            end
         end
         JALR: begin
            if (f3 == 3'b000 && rd == 5'd1 && in_inst[31:20] == '0 && rs1 != '0) begin
               is_c = 1'b1;
               c16  = {3'b100, 1'b1, rs1, 5'd0, Q2};
            end
         end
         SYSTEM: begin
            if (in_inst == EBREAK_INST) begin
               is_c = 1'b1;
               c16  = {3'b100, 1'b1, 5'd0, 5'd0, Q2};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rvc_compress_packer.sv
// Compresses RV32I instructions where possible and packs the resulting
// 16/32-bit parcels into a 32-bit stream, lower halfword first.
// Build option: define RVC_COMPRESS_EN to enable the encoder; otherwise every
// instruction passes through as 32 bits with identical handshake and latency.
module rvc_compress_packer
   import rvc_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_inst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [31:0]      out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             idle,
   output logic [CNT_W-1:0] comp_cnt
);

   logic        is_c;
   logic [15:0] c16;
   pk_state_t   state;
   pk_state_t   state_nxt;
   logic [15:0] pending;
   logic        in_fire;
   logic        flush_go;
   logic        out_load;
   logic [31:0] out_nxt;
   logic        pend_load;
   logic [15:0] pend_nxt;

`ifdef RVC_COMPRESS_EN
   rvc_encoder u_enc (
      .in_inst (in_inst),
      .is_c    (is_c),
      .c16     (c16)
   );
`else
   assign is_c = 1'b0;
   assign c16  = '0;
`endif

   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   // An input transfer always takes priority; flush only acts on an idle input.
   assign flush_go = flush && !in_valid && in_ready && (state == HALF);
   assign idle     = (state == EMPTY) && !out_valid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Next state: a 16-bit parcel toggles the half-fill; 32-bit parcels keep it.
   always_comb begin
      state_nxt = state;
      if (in_fire) begin
         if (is_c) state_nxt = (state == EMPTY) ? HALF : EMPTY;
      end else if (flush_go) begin
         state_nxt = EMPTY;
      end
   end

   // Output decode: what to load into the output and pending registers.
   always_comb begin
      out_load  = 1'b0;
      out_nxt   = out_word;
      pend_load = 1'b0;
      pend_nxt  = pending;
      if (in_fire) begin
         if (state == EMPTY) begin
            if (is_c) begin
               pend_load = 1'b1;
               pend_nxt  = c16;
            end else begin
               out_load  = 1'b1;
               out_nxt   = in_inst;
            end
         end else begin
            out_load  = 1'b1;
            pend_load = 1'b1;
            if (is_c) begin
               out_nxt  = {c16, pending};
               pend_nxt = '0;
            end else begin
               out_nxt  = {in_inst[15:0], pending};
               pend_nxt = in_inst[31:16];
            end
         end
      end else if (flush_go) begin
         out_load  = 1'b1;
         out_nxt   = {C_NOP, pending};
         pend_load = 1'b1;
         pend_nxt  = '0;
      end
   end

   // Output and pending registers; the output holds while stalled downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_word  <= '0;
         pending   <= '0;
      end else begin
         if (in_ready) begin
            out_valid <= out_load;
            if (out_load) out_word <= out_nxt;
         end
         if (pend_load) pending <= pend_nxt;
      end
   end

   // Saturating count of instructions accepted in compressed form.
   always_ff @(posedge clk) begin
      if (rst) begin
         comp_cnt <= '0;
      end else if (in_fire && is_c && comp_cnt != '1) begin
         comp_cnt <= comp_cnt + CNT_W'(1);
      end
   end

endmodule
